load_store_unit: RTL
====================

# load_store_unit

Sequential memory-access engine that executes the load/store commands produced by the control unit (`memWrite`, `memRWSize`, ALU address) against a 32-bit word-addressed data bus. It generates byte-lane strobes, splits misaligned halfword/word accesses into two bus transactions, and merges returned words into a sign- or zero-extended load result for the writeback mux (`WB_DATA_MEM` path). It sits between the execute stage and data memory, with one request outstanding at a time.

## Interface
- No parameters; data and address width fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: command present.
- `req_ready` out 1: unit can accept a command; high only in IDLE.
- `mem_write` in 1: 1 = store, 0 = load.
- `mem_size` in 3: MEM_BYTE_SIGNED=000, MEM_HALFWORD_SIGNED=001, MEM_WORD_SIGNED=010, MEM_BYTE_UNSIGNED=100, MEM_HALFWORD_UNSIGNED=101; other codes are illegal.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: illegal `mem_size`; valid with `resp_valid`.
- `bus_valid` out 1, `bus_ready` in 1: bus request handshake.
- `bus_addr` out 32: word-aligned address, `[1:0]` = 00.
- `bus_we` out 1: write enable.
- `bus_wstrb` out 4: byte-lane enables; lane i is bits `[8i+7:8i]`.
- `bus_wdata` out 32: lane-shifted store data.
- `bus_rvalid` in 1, `bus_rdata` in 32: read return, at least 1 cycle after the read handshake.

## Operation
- **Capture:**
  - A request is accepted on `req_valid && req_ready`.
  - `mem_write`, `mem_size`, `addr`, and `wdata` are registered at accept; inputs are ignored afterwards.
- **Offset and lanes:** `off = addr[1:0]`, byte count n = 1, 2, or 4.
  - First beat lanes are `off .. min(off+n-1, 3)`.
  - If `off+n > 4`, the access splits. The second beat targets `{addr[31:2]+1, 2'b00}` with lanes `0 .. off+n-5`.
  - The second address wraps: `0xFFFFFFFC` to `0x00000000`.
- **Store data:**
  - Beat 0: `bus_wdata = wdata << (8*off)`.
  - Beat 1: `bus_wdata = wdata >> (8*(4-off))`.
  - Lanes not enabled in `bus_wstrb` are don't-care.
- **Reads:** `bus_wstrb` = lane mask, which is informational; memory returns the full word.
  - Bytes from beat 0 lanes, then beat 1 lanes, are packed little-endian into n bytes.
  - Result is sign-extended (`*_SIGNED`) or zero-extended (`*_UNSIGNED`); words need no extension.
- **State machine:**
  - **IDLE:** `req_ready`=1.
    - Accept with legal size → ACC0.
    - Accept with illegal size → RESP with `resp_err`=1; no bus activity.
  - **ACC0:** `bus_valid`=1 with beat-0 fields, held stable until `bus_ready`. On handshake:
    - Store, no split → RESP.
    - Store, split → ACC1.
    - Load → WAIT0.
  - **WAIT0:** on `bus_rvalid`, latch `bus_rdata`, then split → ACC1, no split → RESP.
  - **ACC1:** beat-1 request. On handshake: store → RESP, load → WAIT1.
  - **WAIT1:** on `bus_rvalid`, latch → RESP.
  - **RESP:** `resp_valid`=1 for exactly one cycle → IDLE.
- `bus_rvalid` outside WAIT0/WAIT1 is ignored.

## Timing
- **Reset:**
  - State returns to IDLE.
  - `req_ready`=1; `resp_valid`, `resp_err`, `bus_valid`, `bus_we`=0; `bus_wstrb`=0; `bus_addr`, `bus_wdata`, `resp_rdata`=0.
  - Reset mid-transaction abandons the access; a later `bus_rvalid` is ignored.
- **Registered outputs:** all outputs are registered or decoded from state only; no input→output combinational path except through state.
- **Minimum latency** (accept at cycle T, `bus_ready`=1, `rvalid` 1 cycle after handshake):
  - Aligned store: bus at T+1, `resp_valid` at T+2.
  - Aligned load: bus T+1, rvalid T+2, resp T+3.
  - Split store: beats T+1 and T+2, resp T+3.
  - Split load: beats T+1 and T+3, resp T+5.
  - Illegal size: resp at T+1.
- **Throughput:** no new request is accepted until the cycle after RESP. Back-to-back requests achieve one per (latency+1) cycles.
- **Bus hold:** `bus_ready` low holds all `bus_*` outputs unchanged. `bus_valid` never drops before the handshake.

## Test plan
- **Aligned word load:** `addr`=0x100, size=010, memory word 0x100=0x8000_00FF, `bus_ready`=1 → one beat at 0x100, `wstrb`=1111, `we`=0, `resp_rdata`=0x8000_00FF at T+3.
- **Signed/unsigned byte:** memory 0x200=0x12F4_5678.
  - LB at `addr`=0x202 → `resp_rdata`=0xFFFF_FFF4.
  - LBU at `addr`=0x202 → `resp_rdata`=0x0000_00F4.
- **Misaligned halfword store:** `addr`=0x103, `wdata`=0x0000_BEEF, size=001. Two beats:
  - Beat 0: 0x100, `wstrb`=1000, `wdata[31:24]`=0xEF.
  - Beat 1: 0x104, `wstrb`=0001, `wdata[7:0]`=0xBE.
  - `resp_valid` at T+3.
- **Misaligned word load with wrap:** `addr`=0xFFFF_FFFE, memory 0xFFFF_FFFC=0xAABB_CCDD, memory 0x0=0x1122_3344 → beats at 0xFFFF_FFFC and 0x0000_0000, `resp_rdata`=0x3344_AABB.
- **Bus stall and illegal size:**
  - `bus_ready` low 3 cycles in ACC0 → `bus_*` stable, `resp_valid` delayed exactly 3 cycles.
  - size=111 → `resp_valid`=1 and `resp_err`=1 at T+1, `bus_valid` never asserted.
- **Reset mid-op:** assert `rst` in WAIT0, then pulse `bus_rvalid` → no `resp_valid`, `req_ready`=1 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: command/response handshake and 32-bit data-bus signals of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  modport master (
    output req_valid, mem_write, mem_size, addr, wdata, bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
  );
  modport slave (
    input  req_valid, mem_write, mem_size, addr, wdata, bus_ready, bus_rvalid, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: executes one byte/halfword/word load or store at a time, splitting misaligned accesses into two bus beats
module load_store_unit (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave lsu
);
  typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;
  state_t      state_q, state_d;
  logic        we_q, we_d, err_q, err_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [7:0]  lanes;
  logic        split, legal, bv, b1;
  logic [31:0] merged, load_val;
  // lane mask across both beats, read merge and extension, request legality
  always_comb begin
    lanes = (size_q[1] ? 8'h0F : size_q[0] ? 8'h03 : 8'h01) << addr_q[1:0];
    split = |lanes[7:4];
    merged = 32'({rd1_q, rd0_q} >> {addr_q[1:0], 3'b000});
    load_val = size_q[1] ? merged :
               size_q[0] ? {{16{merged[15] & ~size_q[2]}}, merged[15:0]} :
                           {{24{merged[7] & ~size_q[2]}}, merged[7:0]};
    legal = ~(lsu.mem_size[1] & (lsu.mem_size[0] | lsu.mem_size[2]));
    b1 = state_q == ACC1;
    bv = state_q == ACC0 || b1;
  end
  // state and transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      err_q <= err_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end
  // next state: capture on accept, advance on bus handshakes and read returns
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    err_d = err_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    case (state_q)
      IDLE: if (lsu.req_valid) begin
        we_d = lsu.mem_write;
        size_d = lsu.mem_size;
        addr_d = lsu.addr;
        wdata_d = lsu.wdata;
        err_d = ~legal;
        state_d = legal ? ACC0 : RESP;
      end
      ACC0: if (lsu.bus_ready) state_d = !we_q ? WAIT0 : split ? ACC1 : RESP;
      WAIT0: if (lsu.bus_rvalid) begin
        rd0_d = lsu.bus_rdata;
        state_d = split ? ACC1 : RESP;
      end
      ACC1: if (lsu.bus_ready) state_d = we_q ? RESP : WAIT1;
      WAIT1: if (lsu.bus_rvalid) begin
        rd1_d = lsu.bus_rdata;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state and captured registers only
  always_comb begin
    lsu.req_ready = state_q == IDLE;
    lsu.resp_valid = state_q == RESP;
    lsu.resp_err = state_q == RESP && err_q;
    lsu.resp_rdata = (state_q == RESP && !err_q && !we_q) ? load_val : '0;
    lsu.bus_valid = bv;
    lsu.bus_we = bv && we_q;
    lsu.bus_addr = bv ? {addr_q[31:2] + {29'd0, b1}, 2'b00} : '0;
    lsu.bus_wstrb = !bv ? 4'd0 : b1 ? lanes[7:4] : lanes[3:0];
    lsu.bus_wdata = !bv ? '0 : b1 ? wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000}) : wdata_q << {addr_q[1:0], 3'b000};
  end
endmodule
